dm_lsu: RTL and testbench
=========================

# dm_lsu

Parametrised data-memory load/store unit for the MIPS core's MEM stage. It accepts one load or store request at a time over a valid/ready handshake. Stores go out as byte-lane writes; loads are byte/halfword/word with sign or zero extension. Every accepted request returns exactly one response, with error reporting for illegal, misaligned and out-of-range accesses. Memory is an internal inferred synchronous RAM with byte write enables and a configurable read latency.

## Interface
- DEPTH_LOG2, 11: RAM depth is 2^DEPTH_LOG2 32-bit words.
- RD_LAT, 1: cycles from load acceptance to response; legal values are 1 or 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-aligned.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; a transfer occurs on the edge where req_valid && req_ready.
- req_op  in  4  operation code (dm_pkg).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal op.

## Operation
- Op codes:
  - LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=8, SH=9, SB=10.
  - Bit 3 marks a store.
  - All other codes are illegal.
- Checks are done on the accepted request, with priority illegal > misaligned > out of range:
  - Misaligned: word access with addr[1:0]!=0, or half access with addr[0]!=0.
  - Out of range: addr < BASE_ADDR, or (addr-BASE_ADDR)>>2 >= 2^DEPTH_LOG2.
- Word index is (addr-BASE_ADDR)>>2 truncated to DEPTH_LOG2 bits. Lane is addr[1:0].
- Store data and byte enables:
  - SW: data=wdata, BE=1111.
  - SH: data={2{wdata[15:0]}}, BE=0011 if lane 0, 1100 if lane 2.
  - SB: data={4{wdata[7:0]}}, BE=0001<<lane.
- An error request performs no RAM access: no write, and no read side effects.
- Load extract:
  - Select the byte or half at the lane.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- The op and lane are carried in a pipeline alongside the RAM read so the extract uses the accepted values.
- FSM states:
  - IDLE: req_ready=1.
  - LOAD_WAIT: req_ready=0; a counter runs for RD_LAT cycles.
- FSM transitions:
  - An accepted ok load moves IDLE -> LOAD_WAIT and returns to IDLE on the response cycle.
  - Stores and error requests stay in IDLE.
- RAM contents are not reset and power up undefined.

## Timing
- Reset values:
  - req_ready=0 while reset is low.
  - req_ready=1 on the first edge after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=00.
  - FSM in IDLE, counter 0.
- Store accepted at edge N: RAM is written at edge N; rsp_valid=1 in cycle N+1 with err=00. Back-to-back stores sustain one per cycle.
- Error request accepted at edge N: rsp_valid=1 in cycle N+1 with the error code; no stall.
- Load accepted at edge N:
  - rsp_valid=1 in cycle N+RD_LAT.
  - req_ready=0 in cycles N+1 .. N+RD_LAT-1.
  - req_ready=1 again in cycle N+RD_LAT, so a new request may be accepted on the response cycle.
  - With RD_LAT=1, loads are fully pipelined (one per cycle).
- Store at edge N followed by a load of the same word at edge N+1 returns the new data, including partial byte merges.
- rsp_valid is never asserted without a corresponding accepted request, and is never back-pressured.
- Reset asserted mid-load: the in-flight load is dropped with no response; outputs take reset values immediately (asynchronous).
- req_op/addr/wdata are sampled only on the transfer edge. They are don't-care otherwise.

## Structure
- Package dm_pkg holds:
  - mem_op_t op codes and the is_store bit position.
  - rsp_err codes.
  - The store/load width classification function.
- Sub-module dm_bram_array:
  - Single-port RAM, 2^DEPTH_LOG2 x 32, 4 byte write enables.
  - Synchronous read with RD_LAT-1 extra output register stages.
  - Inferable as block RAM.
- Top level (dm_lsu) holds:
  - Request checking and lane steering.
  - FSM and latency counter.
  - Op/lane sideband pipeline and load extension.

## Test plan
- Reset then SW 0xDEADBEEF @0x10, then LW @0x10: rsp ok, rdata=0xDEADBEEF, arriving RD_LAT cycles after acceptance (test RD_LAT=1 and 2).
- SW 0x11223344 @0x20, SB 0xAA @0x21, SH 0x8001 @0x22, LW @0x20: rdata=0x8001AA44. Then:
  - LB @0x21 gives 0xFFFFFFAA.
  - LBU @0x21 gives 0x000000AA.
  - LH @0x22 gives 0xFFFF8001.
  - LHU @0x22 gives 0x00008001.
- LW @0x22 gives err=01. SH @0x23 gives err=01. op=5 gives err=11. LW @ BASE_ADDR+4*2^DEPTH_LOG2 gives err=10. None of these changes RAM (verify by readback), and each responds in cycle N+1.
- RD_LAT=2 with req_valid held high over 3 loads: req_ready low exactly one cycle per load, 3 responses in order, no duplicates.
- Drive reset low one cycle after accepting a load with RD_LAT=2: no rsp_valid ever appears for it, all outputs return to reset values, and the next request after release is served normally.
- Random mix of 10k requests checked against a byte-array scoreboard model with the same error rules.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory load/store unit: op codes,
// response error codes and the access-width classification.
package dm_pkg;

    typedef enum logic [3:0] {
        OP_LW  = 4'd0,
        OP_LH  = 4'd1,
        OP_LHU = 4'd2,
        OP_LB  = 4'd3,
        OP_LBU = 4'd4,
        OP_SW  = 4'd8,
        OP_SH  = 4'd9,
        OP_SB  = 4'd10
    } mem_op_t;

    localparam int OP_STORE_BIT = 3;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } rsp_err_t;

    typedef enum logic [1:0] {
        W_BYTE,
        W_HALF,
        W_WORD,
        W_NONE
    } acc_width_t;

    // W_NONE doubles as the illegal-op marker.
    function automatic acc_width_t op_width(input logic [3:0] op);
        acc_width_t w;
        case (op)
            OP_LW, OP_SW:          w = W_WORD;
            OP_LH, OP_LHU, OP_SH:  w = W_HALF;
            OP_LB, OP_LBU, OP_SB:  w = W_BYTE;
            default:               w = W_NONE;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dm_bram_array.sv
// Single-port 32-bit RAM with byte write enables and a synchronous read,
// plus an optional output register when two cycles of read latency are wanted.
module dm_bram_array #(
    parameter int DEPTH_LOG2 = 11,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [3:0]            we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem [2**DEPTH_LOG2];
    logic [31:0] rd_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            if (we_i == 4'b0000) begin
                rd_q <= mem[addr_i];
            end
        end
    end

    generate
        if (RD_LAT > 1) begin : g_out_reg
            logic [31:0] out_q;
            always_ff @(posedge clk) begin
                out_q <= rd_q;
            end
            assign rdata_o = out_q;
        end else begin : g_no_out_reg
            assign rdata_o = rd_q;
        end
    endgenerate

endmodule

// File: rtl/dm_lsu.sv
// MEM-stage load/store unit: checks and steers one request per transfer,
// drives the byte-lane RAM and extends load data on the way back.
//
// state       | meaning
// S_IDLE      | ready for any request
// S_LOAD_WAIT | load in flight; ready again when cnt_q reaches 0 (response cycle)
module dm_lsu
    import dm_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 11,
    parameter int          RD_LAT     = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err
);

    typedef enum logic {
        S_IDLE,
        S_LOAD_WAIT
    } state_t;

    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    logic        req_fire;
    logic        is_store;
    logic        ok;
    logic        ld_fire;
    acc_width_t  wid;
    logic [1:0]  lane;
    logic [31:0] off;
    rsp_err_t    chk_err;
    logic [3:0]  be;
    logic [31:0] st_data;

    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        live_q;
    logic        fsm_ready;

    logic [RD_LAT-1:0] pv_q;
    logic [3:0]        op_q   [RD_LAT];
    logic [1:0]        lane_q [RD_LAT];
    logic              imm_vld_q;
    rsp_err_t          imm_err_q;

    logic        ld_vld;
    logic [3:0]  ld_op;
    logic [1:0]  ld_lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_word;

    assign req_fire = req_valid && req_ready;
    assign wid      = op_width(req_op);
    assign is_store = req_op[OP_STORE_BIT];
    assign lane     = req_addr[1:0];
    assign off      = req_addr - BASE_ADDR;

    always_comb begin
        chk_err = ERR_OK;
        if (wid == W_NONE) begin
            chk_err = ERR_ILLEGAL;
        end else if ((wid == W_WORD && lane != 2'b00) || (wid == W_HALF && lane[0])) begin
            chk_err = ERR_MISALIGN;
        end else if (req_addr < BASE_ADDR || (off >> (DEPTH_LOG2 + 2)) != 32'd0) begin
            chk_err = ERR_RANGE;
        end
    end

    assign ok      = (chk_err == ERR_OK);
    assign ld_fire = req_fire && ok && !is_store;

    // Replicate narrow store data across lanes so the byte enables alone pick the target.
    always_comb begin
        be      = 4'b0000;
        st_data = req_wdata;
        case (wid)
            W_WORD: be = 4'b1111;
            W_HALF: begin
                st_data = {2{req_wdata[15:0]}};
                be      = lane[1] ? 4'b1100 : 4'b0011;
            end
            W_BYTE: begin
                st_data = {4{req_wdata[7:0]}};
                be      = 4'b0001 << lane;
            end
            default: be = 4'b0000;
        endcase
    end

    assign ram_en = req_fire && ok;
    assign ram_we = (req_fire && ok && is_store) ? be : 4'b0000;

    dm_bram_array #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .RD_LAT    (RD_LAT)
    ) u_ram (
        .clk    (clk),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .addr_i (off[DEPTH_LOG2+1:2]),
        .wdata_i(st_data),
        .rdata_o(ram_rdata)
    );

    assign fsm_ready = (state_q == S_IDLE) || (cnt_q == 2'd0);
    assign req_ready = live_q && fsm_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_LOAD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
        endcase
        // A load accepted on the response cycle re-arms the wait immediately.
        if (ld_fire) begin
            state_d = S_LOAD_WAIT;
            cnt_d   = LAT_M1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i]   <= 1'b0;
                op_q[i]   <= 4'd0;
                lane_q[i] <= 2'd0;
            end
            imm_vld_q <= 1'b0;
            imm_err_q <= ERR_OK;
        end else begin
            pv_q[0]   <= ld_fire;
            op_q[0]   <= req_op;
            lane_q[0] <= lane;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i]   <= pv_q[i-1];
                op_q[i]   <= op_q[i-1];
                lane_q[i] <= lane_q[i-1];
            end
            imm_vld_q <= req_fire && (!ok || is_store);
            imm_err_q <= chk_err;
        end
    end

    assign ld_vld  = pv_q[RD_LAT-1];
    assign ld_op   = op_q[RD_LAT-1];
    assign ld_lane = lane_q[RD_LAT-1];

    always_comb begin
        case (ld_lane)
            2'd0:    ld_byte = ram_rdata[7:0];
            2'd1:    ld_byte = ram_rdata[15:8];
            2'd2:    ld_byte = ram_rdata[23:16];
            default: ld_byte = ram_rdata[31:24];
        endcase
        ld_half = ld_lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (ld_op)
            OP_LB:   ld_word = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_word = {24'd0, ld_byte};
            OP_LH:   ld_word = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_word = {16'd0, ld_half};
            default: ld_word = ram_rdata;
        endcase
    end

    assign rsp_valid = imm_vld_q || ld_vld;
    assign rsp_err   = imm_vld_q ? imm_err_q : ERR_OK;
    assign rsp_rdata = ld_vld ? ld_word : 32'd0;

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: two instances (read latency 1 at base 0, latency 2 at base 0x1000)
// checked against a byte-array model through per-instance expectation queues.
module tb_dm_lsu;

    localparam int          DL    = 6;
    localparam int          NB    = 4 << DL;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_1000;

    localparam logic [3:0] LW = 4'd0, LH = 4'd1, LHU = 4'd2, LB = 4'd3, LBU = 4'd4;
    localparam logic [3:0] SW = 4'd8, SH = 4'd9, SB = 4'd10;

    typedef struct {
        int          cyc;
        logic [1:0]  err;
        logic [31:0] data;
        logic        chkd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        rv    [2];
    logic        rr    [2];
    logic        vv    [2];
    logic [3:0]  rop   [2];
    logic [31:0] radr  [2];
    logic [31:0] rwd   [2];
    logic [31:0] rdat  [2];
    logic [1:0]  rerr  [2];

    exp_t q0[$];
    exp_t q1[$];

    logic [7:0] mm [2][NB];
    logic       kn [2][NB];

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;
    int low1  = 0;

    dm_lsu #(.DEPTH_LOG2(DL), .RD_LAT(1), .BASE_ADDR(BASE0)) u_dut0 (
        .clk(clk), .reset(rst_n[0]), .req_valid(rv[0]), .req_ready(rr[0]),
        .req_op(rop[0]), .req_addr(radr[0]), .req_wdata(rwd[0]),
        .rsp_valid(vv[0]), .rsp_rdata(rdat[0]), .rsp_err(rerr[0])
    );

    dm_lsu #(.DEPTH_LOG2(DL), .RD_LAT(2), .BASE_ADDR(BASE1)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .req_valid(rv[1]), .req_ready(rr[1]),
        .req_op(rop[1]), .req_addr(radr[1]), .req_wdata(rwd[1]),
        .rsp_valid(vv[1]), .rsp_rdata(rdat[1]), .rsp_err(rerr[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? BASE0 : BASE1;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    task automatic model_accept(input int d, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] wd, input bit xv,
                                input logic [31:0] xd, input logic [1:0] xe);
        exp_t        e;
        int          sz;
        bit          st;
        bit          legal;
        logic [31:0] off;
        logic [31:0] w;
        int          bi;
        e.data = 32'd0;
        e.chkd = 1'b1;
        e.err  = 2'b00;
        legal  = 1'b1;
        st     = 1'b0;
        sz     = 0;
        case (op)
            LW:        sz = 4;
            LH, LHU:   sz = 2;
            LB, LBU:   sz = 1;
            SW: begin  sz = 4; st = 1'b1; end
            SH: begin  sz = 2; st = 1'b1; end
            SB: begin  sz = 1; st = 1'b1; end
            default:   legal = 1'b0;
        endcase
        off = a - base_of(d);
        if (!legal)                                e.err = 2'b11;
        else if ((int'(a[1:0]) % sz) != 0)         e.err = 2'b01;
        else if (a < base_of(d) || off >= 32'(NB)) e.err = 2'b10;
        e.cyc = cyc + ((e.err == 2'b00 && !st) ? lat_of(d) : 1);
        if (e.err == 2'b00) begin
            bi = int'(off);
            if (st) begin
                for (int k = 0; k < sz; k++) begin
                    mm[d][bi+k] = wd[8*k +: 8];
                    kn[d][bi+k] = 1'b1;
                end
            end else begin
                w = 32'd0;
                for (int k = 0; k < sz; k++) begin
                    w[8*k +: 8] = mm[d][bi+k];
                    if (!kn[d][bi+k]) e.chkd = 1'b0;
                end
                if (op == LH) w = {{16{w[15]}}, w[15:0]};
                if (op == LB) w = {{24{w[7]}}, w[7:0]};
                e.data = w;
            end
        end
        if (xv) begin
            e.data = xd;
            e.err  = xe;
            e.chkd = 1'b1;
        end
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic issue(input int d, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] wd = 32'd0, input bit xv = 1'b0,
                         input logic [31:0] xd = 32'd0, input logic [1:0] xe = 2'b00);
        int n = 0;
        rv[d]   = 1'b1;
        rop[d]  = op;
        radr[d] = a;
        rwd[d]  = wd;
        while (!rr[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rr[d]) begin
            chk($sformatf("d%0d_ready_timeout", d), 32'd0, 32'd1);
            rv[d] = 1'b0;
            return;
        end
        model_accept(d, op, a, wd, xv, xd, xe);
        @(negedge clk);
        rv[d]   = 1'b0;
        rop[d]  = 4'hF;
        radr[d] = 32'hXXXX_XXXX;
        rwd[d]  = 32'hXXXX_XXXX;
    endtask

    task automatic check_rsp(input int d);
        exp_t e;
        bit   empty;
        empty = 1'b0;
        if (d == 0) begin
            if (q0.size() == 0) empty = 1'b1;
            else                e = q0.pop_front();
        end else begin
            if (q1.size() == 0) empty = 1'b1;
            else                e = q1.pop_front();
        end
        if (empty) begin
            chk($sformatf("d%0d_unexpected_rsp", d), 32'd1, 32'd0);
            return;
        end
        chk($sformatf("d%0d_rsp_cycle", d), cyc, e.cyc);
        chk($sformatf("d%0d_rsp_err", d), 32'(rerr[d]), 32'(e.err));
        if (e.chkd) chk($sformatf("d%0d_rsp_rdata", d), rdat[d], e.data);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n[d] && vv[d]) check_rsp(d);
        end
        if (rst_n[1] && !rr[1]) low1++;
    end

    task automatic chk_reset_outputs(input int d, input string tag);
        chk($sformatf("d%0d_%s_ready", d, tag), 32'(rr[d]), 32'd0);
        chk($sformatf("d%0d_%s_valid", d, tag), 32'(vv[d]), 32'd0);
        chk($sformatf("d%0d_%s_rdata", d, tag), rdat[d], 32'd0);
        chk($sformatf("d%0d_%s_err", d, tag), 32'(rerr[d]), 32'd0);
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b;
        int          p;
        logic [3:0]  op;
        logic [31:0] a;
        logic [3:0]  ops [10];
        ops = '{LW, LH, LHU, LB, LBU, SW, SH, SB, 4'd5, 4'd11};

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            rv[d]    = 1'b0;
            rop[d]   = 4'd0;
            radr[d]  = 32'd0;
            rwd[d]   = 32'd0;
            for (int i = 0; i < NB; i++) kn[d][i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) chk_reset_outputs(d, "rst");
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) chk($sformatf("d%0d_ready_pre_edge", d), 32'(rr[d]), 32'd0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("d%0d_ready_post_edge", d), 32'(rr[d]), 32'd1);

        // Directed sequences on both latencies.
        for (int d = 0; d < 2; d++) begin
            b = base_of(d);
            issue(d, SW,  b + 32'h10, 32'hDEAD_BEEF);
            issue(d, LW,  b + 32'h10, 32'd0, 1'b1, 32'hDEAD_BEEF, 2'b00);
            issue(d, SW,  b + 32'h00, 32'h0BAD_F00D);
            issue(d, SW,  b + 32'h20, 32'h1122_3344);
            issue(d, SB,  b + 32'h21, 32'h0000_00AA);
            issue(d, SH,  b + 32'h22, 32'h0000_8001);
            issue(d, LW,  b + 32'h20, 32'd0, 1'b1, 32'h8001_AA44, 2'b00);
            issue(d, LB,  b + 32'h21, 32'd0, 1'b1, 32'hFFFF_FFAA, 2'b00);
            issue(d, LBU, b + 32'h21, 32'd0, 1'b1, 32'h0000_00AA, 2'b00);
            issue(d, LH,  b + 32'h22, 32'd0, 1'b1, 32'hFFFF_8001, 2'b00);
            issue(d, LHU, b + 32'h22, 32'd0, 1'b1, 32'h0000_8001, 2'b00);
            issue(d, LW,  b + 32'h22, 32'd0, 1'b1, 32'd0, 2'b01);
            issue(d, SH,  b + 32'h23, 32'h0000_FFFF, 1'b1, 32'd0, 2'b01);
            issue(d, 4'd5, b + 32'h20, 32'd0, 1'b1, 32'd0, 2'b11);
            issue(d, 4'd11, b + 32'h20, 32'h5555_5555, 1'b1, 32'd0, 2'b11);
            issue(d, LW,  b + 32'(NB), 32'd0, 1'b1, 32'd0, 2'b10);
            issue(d, SW,  b + 32'(NB), 32'h7777_7777, 1'b1, 32'd0, 2'b10);
            issue(d, LW,  b + 32'(NB) + 32'd1, 32'd0, 1'b1, 32'd0, 2'b01);
            issue(d, LW,  b + 32'h20, 32'd0, 1'b1, 32'h8001_AA44, 2'b00);
            issue(d, LW,  b + 32'h00, 32'd0, 1'b1, 32'h0BAD_F00D, 2'b00);
            repeat (4) @(negedge clk);
        end
        issue(1, LB, BASE1 - 32'd1, 32'd0, 1'b1, 32'd0, 2'b10);
        repeat (3) @(negedge clk);

        // Latency-2 burst with valid held: one stall cycle per load.
        low1 = 0;
        issue(1, LW, BASE1 + 32'h10);
        issue(1, LW, BASE1 + 32'h20);
        issue(1, LW, BASE1 + 32'h00);
        repeat (3) @(negedge clk);
        chk("d1_burst_ready_low_cycles", low1, 32'd3);

        // Reset while a load is in flight: dropped, outputs clear at once.
        issue(1, LW, BASE1 + 32'h10);
        rst_n[1] = 1'b0;
        q1.delete();
        #1;
        chk_reset_outputs(1, "midload");
        repeat (3) @(negedge clk);
        chk_reset_outputs(1, "midload_hold");
        rst_n[1] = 1'b1;
        @(negedge clk);
        issue(1, LW, BASE1 + 32'h10, 32'd0, 1'b1, 32'hDEAD_BEEF, 2'b00);
        repeat (4) @(negedge clk);

        // Random mix against the byte model.
        for (int d = 0; d < 2; d++) begin
            b = base_of(d);
            for (int w = 0; w < 16; w++) issue(d, SW, b + 32'(4 * w), $urandom);
            for (int n = 0; n < 5000; n++) begin
                op = ops[$urandom_range(0, 9)];
                p  = $urandom_range(0, 9);
                if (p < 8)       a = b + 32'($urandom_range(0, 63));
                else if (p == 8) a = b + 32'(NB) + 32'($urandom_range(0, 15));
                else if (d == 1) a = b - 32'($urandom_range(1, 16));
                else             a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
                if ($urandom_range(0, 7) == 0) @(negedge clk);
                issue(d, op, a, $urandom);
            end
            repeat (4) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("d0_pending_rsp", q0.size(), 32'd0);
        chk("d1_pending_rsp", q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
